// File: rtl/transcr_stream_ctrl_pkg.sv
// Shared types and constants for the transcr stream sequencer.
// TRANSCR_LAT and TW describe the external transcr pipeline the parent instantiates.
package transcr_stream_ctrl_pkg;

  localparam int TRANSCR_LAT = 6;
  localparam int TW          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
  } result_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transcr_stream_ctrl_if.sv
// Pixel-in, result-out and transcr pipeline signals of the stream sequencer.
// slave is the sequencer's view; master is the surrounding environment.
interface transcr_stream_ctrl_if;
  import transcr_stream_ctrl_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_Y;
  logic [7:0]    in_Cr;
  logic [7:0]    pipe_Y;
  logic [7:0]    pipe_Cr;
  logic [TW-1:0] pipe_transcr;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;

  modport slave (
    input  in_valid, in_Y, in_Cr, pipe_transcr, out_ready,
    output in_ready, pipe_Y, pipe_Cr, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport master (
    output in_valid, in_Y, in_Cr, pipe_transcr, out_ready,
    input  in_ready, pipe_Y, pipe_Cr, out_valid, out_data, out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/transcr_stream_ctrl_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head whenever !empty.
// Reads on empty are dropped; a write on full is accepted only alongside a read.
module transcr_stream_ctrl_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_rd   = rd_en && (count_q != '0);
    do_wr   = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
    wptr_d  = wptr_q + AW'(do_wr);
    rptr_d  = rptr_q + AW'(do_rd);
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
    mem_d   = mem_q;
    if (do_wr) mem_d[wptr_q] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/transcr_stream_ctrl.sv
// Frame sequencer feeding the non-stallable transcr pipeline with credit-based flow control.
// States: IDLE wait start | RUN accept pixels | DRAIN empty pipe+FIFO | DONE one-cycle done.
module transcr_stream_ctrl
  import transcr_stream_ctrl_pkg::*;
#(
  parameter int PIPE_LAT   = TRANSCR_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  transcr_stream_ctrl_if.slave bus
);

  localparam int XW = cnt_w(FRAME_W);
  localparam int YW = cnt_w(FRAME_H);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_W-1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_H-1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [7:0]    pipe_y_q, pipe_y_d;
  logic [7:0]    pipe_cr_q, pipe_cr_d;
  tag_t          tag_q [PIPE_LAT+1];
  tag_t          tag_d [PIPE_LAT+1];

  logic          in_rdy, credit_ok, accept, ret;
  logic          sof, eol, eof;
  result_t       fifo_wdata, fifo_rdata;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && eof) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && (inflight_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    in_rdy = 1'b0;
    unique case (state_q)
      ST_RUN:   begin busy = 1'b1; in_rdy = credit_ok; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Credits count everything already committed to the FIFO: in flight plus stored.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_C;
  assign accept    = bus.in_valid && in_rdy;
  assign ret       = tag_q[PIPE_LAT].vld;

  always_comb begin
    sof        = (x_q == '0) && (y_q == '0);
    eol        = (x_q == X_LAST);
    eof        = eol && (y_q == Y_LAST);
    x_d        = x_q;
    y_d        = y_q;
    pipe_y_d   = pipe_y_q;
    pipe_cr_d  = pipe_cr_q;
    inflight_d = inflight_q + CW'(accept) - CW'(ret);
    if ((state_q == ST_IDLE) && start) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (eol) begin
        x_d = '0;
        y_d = eof ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    if (accept) begin
      pipe_y_d  = bus.in_Y;
      pipe_cr_d = bus.in_Cr;
    end
  end

  // The tag line is one stage longer than the pipe because pipe_Y is itself a register.
  always_comb begin
    tag_d[0] = accept ? '{vld: 1'b1, sof: sof, eol: eol, eof: eof} : '0;
    for (int i = 1; i <= PIPE_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      pipe_y_q   <= '0;
      pipe_cr_q  <= '0;
      tag_q      <= '{default: '0};
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      pipe_y_q   <= pipe_y_d;
      pipe_cr_q  <= pipe_cr_d;
      tag_q      <= tag_d;
    end
  end

  assign fifo_wdata = '{data: bus.pipe_transcr, sof: tag_q[PIPE_LAT].sof,
                        eol: tag_q[PIPE_LAT].eol, eof: tag_q[PIPE_LAT].eof};

  transcr_stream_ctrl_stream_fifo #(
    .W     ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ret),
    .wr_data (fifo_wdata),
    .rd_en   (bus.out_ready),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(ret && fifo_full));

  assign bus.in_ready  = in_rdy;
  assign bus.pipe_Y    = pipe_y_q;
  assign bus.pipe_Cr   = pipe_cr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_rdata.data;
  assign bus.out_sof   = fifo_rdata.sof;
  assign bus.out_eol   = fifo_rdata.eol;
  assign bus.out_eof   = fifo_rdata.eof;

endmodule

// File: tb/tb_transcr_stream_ctrl.sv
// Scoreboard bench for transcr_stream_ctrl on a 4x2 frame; transcr is a pure delay of {Y,Cr}.
module tb_transcr_stream_ctrl;
  import transcr_stream_ctrl_pkg::*;

  localparam int PIPE_LAT = TRANSCR_LAT;
  localparam int DEPTH    = 8;
  localparam int W        = 4;
  localparam int H        = 2;
  localparam int NPIX     = W * H;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  transcr_stream_ctrl_if bus ();

  transcr_stream_ctrl #(
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (DEPTH),
    .FRAME_W    (W),
    .FRAME_H    (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // transcr stand-in: result equals {Y,Cr} seen PIPE_LAT cycles earlier
  logic [15:0] dl [PIPE_LAT];
  always @(posedge clk) begin
    dl[0] <= {bus.pipe_Y, bus.pipe_Cr};
    for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
  end
  assign bus.pipe_transcr = dl[PIPE_LAT-1];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  bit   mon_en = 1'b0;
  bit   m_idle = 1'b1;
  int   m_pix = 0, m_out = 0, m_pops = 0, exp_done_cyc = -1, done_cnt = 0;
  logic [7:0]  m_last_y = '0, m_last_cr = '0;
  bit          prev_hold = 1'b0;
  logic [18:0] prev_out = '0;
  int   first_acc_cyc = 0, first_ov_cyc = -1, first_pop_cyc = 0, last_pop_cyc = 0, act_done_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks the cycle's outputs against the model, then advances the model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   acc, pop;
      exp_t e;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      check("in_ready", bus.in_ready, (!m_idle && m_pix < NPIX && m_out < DEPTH));
      check("busy", busy, (!m_idle && cyc != exp_done_cyc));
      check("done", done, (cyc == exp_done_cyc));
      check("pipe_Y", bus.pipe_Y, m_last_y);
      check("pipe_Cr", bus.pipe_Cr, m_last_cr);
      if (prev_hold)
        check("out_hold", {bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof},
              {1'b1, prev_out});
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_out  = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
      if (done) act_done_cyc = cyc;
      if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (pop) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h expected none at cycle %0d", bus.out_data, cyc);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_tags", {bus.out_sof, bus.out_eol, bus.out_eof}, {e.sof, e.eol, e.eof});
        end
        if (m_pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        m_pops++;
        if (m_pops == NPIX) exp_done_cyc = cyc + 2;
      end
      if (acc) begin
        e.d   = {bus.in_Y, bus.in_Cr};
        e.sof = (m_pix == 0);
        e.eol = ((m_pix % W) == W - 1);
        e.eof = (m_pix == NPIX - 1);
        sb.push_back(e);
        if (m_pix == 0) first_acc_cyc = cyc;
        m_pix++;
        m_last_y  = bus.in_Y;
        m_last_cr = bus.in_Cr;
      end
      m_out = m_out + int'(acc) - int'(pop);
      if (cyc == exp_done_cyc) begin
        m_idle = 1'b1;
        done_cnt++;
      end else if (start && m_idle) begin
        m_idle       = 1'b0;
        m_pix        = 0;
        m_pops       = 0;
        first_ov_cyc = -1;
        exp_done_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.in_Y  = 8'($urandom);
    bus.in_Cr = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame_end(input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (done_cnt == n0) begin
      bad++;
      $display("FAIL frame_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_pipe_Y"}, bus.pipe_Y, 0);
    check({tag, "_pipe_Cr"}, bus.pipe_Cr, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_idle       = 1'b1;
    m_pix        = 0;
    m_out        = 0;
    m_pops       = 0;
    exp_done_cyc = -1;
    m_last_y     = '0;
    m_last_cr    = '0;
    prev_hold    = 1'b0;
  endtask

  initial begin
    void'($urandom(32'd20240611));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_Y      = '0;
    bus.in_Cr     = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: full rate in and out
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    pulse_start();
    wait_frame_end(200);
    check("t1_latency", first_ov_cyc - first_acc_cyc, PIPE_LAT + 2);
    check("t1_burst", last_pop_cyc - first_pop_cyc, NPIX - 1);
    check("t1_done_time", act_done_cyc - first_acc_cyc, PIPE_LAT + 2 + NPIX - 1 + 2);

    // 4: start during RUN is ignored
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_frame_end(200);
    check("t4_pixels", m_pix, NPIX);
    check("t4_done_time", act_done_cyc - first_acc_cyc, PIPE_LAT + 2 + NPIX - 1 + 2);

    // 2: downstream stalled
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (30) tick();
    check("t2_accepts", m_pix, NPIX);
    check("t2_in_ready", bus.in_ready, 0);
    check("t2_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait_frame_end(200);

    // 6: input gap in RUN
    pulse_start();
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (15) tick();
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    wait_frame_end(200);

    // 5: reset with pixels in flight, then a clean frame
    pulse_start();
    repeat (5) tick();
    check("t5_inflight", m_out, 5);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    model_reset();
    tick();
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    pulse_start();
    wait_frame_end(200);

    // 3: random valid/ready with occasional stray starts
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      start         = m_idle ? 1'b1 : ($urandom_range(0, 15) == 0);
      tick();
    end
    start         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    if (!m_idle) wait_frame_end(500);
    repeat (3) tick();
    check("t3_many_frames", (done_cnt > 100), 1);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
